// File: rtl/div_pkg.sv
// Shared types and constants for the 8/4 restoring divider.
// Widths are fixed here rather than parameterised on the top.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int STEP_W     = 3;

    localparam logic [STEP_W-1:0]     LAST_STEP    = 3'd7;
    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// trial-subtract the divisor and keep the difference only if it did not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] diff;

    assign shifted = {rem_in, next_bit};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};

    // No borrow out of the 5-bit subtract means shifted >= divisor.
    assign q_bit   = ~diff[DIVISOR_W+1];
    assign rem_out = q_bit ? diff[DIVISOR_W:0] : shifted;

endmodule

// File: rtl/div8x4.sv
// Sequential 8-bit by 4-bit restoring divider, one quotient bit per clock,
// using the same start/done_flag handshake as the 4x4 shift-add multiplier.
module div8x4
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_a_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient_out,
    output logic [DIVISOR_W-1:0]  remainder_out,
    output logic                  busy,
    output logic                  done_flag,
    output logic                  div_by_zero
);

    state_t                state, state_next;
    logic [DIVIDEND_W-1:0] q, q_next;
    logic [DIVISOR_W:0]    r, r_next;
    logic [DIVISOR_W-1:0]  d, d_next;
    logic [STEP_W-1:0]     cnt, cnt_next;
    logic                  dbz, dbz_next;
    logic                  busy_next, done_next;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_bit;

    div_step u_step (
        .rem_in   (r[DIVISOR_W-1:0]),
        .next_bit (q[DIVIDEND_W-1]),
        .divisor  (d),
        .rem_out  (step_rem),
        .q_bit    (step_bit)
    );

    // The partial remainder is always below the divisor between steps, so its
    // top bit only matters inside div_step's 5-bit compare.
    logic unused_r_msb;
    assign unused_r_msb = r[DIVISOR_W];

    always_comb begin
        state_next = state;
        q_next     = q;
        r_next     = r;
        d_next     = d;
        cnt_next   = cnt;
        dbz_next   = dbz;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    q_next     = dividend;
                    d_next     = divisor;
                    r_next     = '0;
                    cnt_next   = '0;
                    dbz_next   = 1'b0;
                    state_next = CALC;
                end
            end
            CALC: begin
                // A zero divisor spends a single busy cycle, then reports the
                // saturated quotient and the low dividend nibble.
                if (d == '0) begin
                    q_next     = DBZ_QUOTIENT;
                    r_next     = {1'b0, q[DIVISOR_W-1:0]};
                    dbz_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    q_next   = {q[DIVIDEND_W-2:0], step_bit};
                    r_next   = step_rem;
                    cnt_next = cnt + 3'd1;
                    if (cnt == LAST_STEP) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == CALC);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            state     <= IDLE;
            q         <= '0;
            r         <= '0;
            d         <= '0;
            cnt       <= '0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            state     <= state_next;
            q         <= q_next;
            r         <= r_next;
            d         <= d_next;
            cnt       <= cnt_next;
            dbz       <= dbz_next;
            busy      <= busy_next;
            done_flag <= done_next;
        end
    end

    assign quotient_out  = q;
    assign remainder_out = r[DIVISOR_W-1:0];
    assign div_by_zero   = dbz;

endmodule

// File: tb/tb_div8x4.sv
// Directed bench for div8x4: hand-computed quotients/remainders, latency,
// handshake behaviour, divide-by-zero and asynchronous reset mid-run.
module tb_div8x4;

    logic       clk = 1'b0;
    logic       reset_a_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient_out;
    logic [3:0] remainder_out;
    logic       busy;
    logic       done_flag;
    logic       div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    div8x4 dut (
        .clk           (clk),
        .reset_a_n     (reset_a_n),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .busy          (busy),
        .done_flag     (done_flag),
        .div_by_zero   (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle; returns #1 after the accepting edge, with the
    // operand inputs scrambled so any late re-sampling shows up.
    task automatic do_start(input logic [7:0] dvd, input logic [3:0] dvs);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~dvd;
        divisor  = ~dvs;
    endtask

    // Count edges until done_flag; -1 if it never arrives within the budget.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done_flag) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] eq, input logic [3:0] er,
                                input logic edbz);
        chk({tag, "_quot"}, quotient_out, eq);
        chk({tag, "_rem"}, remainder_out, er);
        chk({tag, "_dbz"}, div_by_zero, edbz);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic run_div(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                           input logic [7:0] eq, input logic [3:0] er, input int elat);
        int c;
        do_start(dvd, dvs);
        chk({tag, "_busy_on_accept"}, busy, 1'b1);
        chk({tag, "_done_low_on_accept"}, done_flag, 1'b0);
        wait_done(c);
        chk({tag, "_latency"}, c, elat);
        check_result(tag, eq, er, 1'b0);
    endtask

    initial begin
        reset_a_n = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1 reset_a_n = 1'b0;
        #11;
        chk("rst_quot", quotient_out, 8'd0);
        chk("rst_rem", remainder_out, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done_flag, 1'b0);
        chk("rst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        reset_a_n = 1'b1;

        // Basic case, then confirm the result holds while start stays low.
        run_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 8);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_quot", quotient_out, 8'd28);
        chk("hold_rem", remainder_out, 4'd4);
        chk("hold_done", done_flag, 1'b1);

        run_div("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 8);
        run_div("d225_15", 8'd225, 4'd15, 8'd15, 4'd0, 8);
        run_div("d0_5", 8'd0, 4'd5, 8'd0, 4'd0, 8);
        run_div("d14_15", 8'd14, 4'd15, 8'd0, 4'd14, 8);
        repeat (2) @(posedge clk);
        #1;
        chk("hold14_rem", remainder_out, 4'd14);

        // Divide by zero: one busy cycle, saturated quotient, low nibble remainder.
        do_start(8'h9A, 4'd0);
        chk("dbz_busy_on_accept", busy, 1'b1);
        chk("dbz_flag_low_while_busy", div_by_zero, 1'b0);
        wait_done(lat);
        chk("dbz_latency", lat, 1);
        check_result("dbz", 8'hFF, 4'hA, 1'b1);
        run_div("d100_10", 8'd100, 4'd10, 8'd10, 4'd0, 8);

        // Start mid-run is ignored: result arrives 8 edges after the first start.
        do_start(8'd100, 4'd3);
        repeat (2) @(posedge clk);
        do_start(8'd50, 4'd5);
        chk("ign_busy", busy, 1'b1);
        wait_done(lat);
        chk("ign_latency_rest", lat, 5);
        check_result("ign", 8'd33, 4'd1, 1'b0);

        // Back-to-back: restart on the cycle done_flag is seen.
        do_start(8'd200, 4'd7);
        wait_done(lat);
        chk("b2b_first_latency", lat, 8);
        chk("b2b_first_quot", quotient_out, 8'd28);
        run_div("b2b_99_9", 8'd99, 4'd9, 8'd11, 4'd0, 8);

        // Asynchronous reset in the middle of a run.
        do_start(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #2 reset_a_n = 1'b0;
        #1;
        chk("mid_rst_quot", quotient_out, 8'd0);
        chk("mid_rst_rem", remainder_out, 4'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done_flag, 1'b0);
        chk("mid_rst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        reset_a_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", busy, 1'b0);
        chk("post_rst_idle_done", done_flag, 1'b0);
        run_div("d64_8", 8'd64, 4'd8, 8'd8, 4'd0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
